reg_lock_tracker: RTL and testbench

Sequential register-lock scoreboard that holds the pipeline's locked-register state. It consumes dispatch events from the issue arbiter and register releases from the write-back ports. It drives `locks_o` into the lock-grant checker's `locks_i`, closing the lock/check loop. Each register has an outstanding-write counter, so back-to-back writes to the same destination keep it locked until the last one retires. Jumps lock the whole file until resolved.

---
 rtl/reg_lock_tracker.sv | 115 +++++++++++
 tb/tb_reg_lock_tracker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: per-register outstanding-write counters plus a global
// jump lock, feeding the lock-grant checker with a purely registered lock vector.

package rv64g_pkg;
    localparam int NUM_REGS = 32;
endpackage

module reg_lock_tracker #(
    parameter int NR  = rv64g_pkg::NUM_REGS,
    parameter int CW  = 2,
    parameter int NWB = 2
) (
    input  logic                            clk_i,
    input  logic                            arst_i,
    input  logic                            flush_i,
    input  logic                            dispatch_valid_i,
    input  logic                            dispatch_jump_i,
    input  logic [$clog2(NR)-1:0]           dispatch_rd_i,
    input  logic                            jump_done_i,
    input  logic [NWB-1:0]                  wb_valid_i,
    input  logic [NWB-1:0][$clog2(NR)-1:0]  wb_rd_i,
    output logic [NR-1:0]                   locks_o,
    output logic [NR-1:0]                   rd_full_o,
    output logic                            jump_lock_o,
    output logic                            overflow_o,
    output logic                            underflow_o
);

    localparam int AW = $clog2(NR);
    localparam int DW = $clog2(NWB + 1);
    localparam int SW = CW + DW + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [SW-1:0] SUM_MAX = {{(SW-CW){1'b0}}, CNT_MAX};

    logic [NR-1:0][CW-1:0] r_cnt;
    logic                  r_jumpLock;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [NR-1:0][CW-1:0] w_cntNext;
    logic [NR-1:0]         w_ovfHit;
    logic [NR-1:0]         w_unfHit;
    logic                  w_jumpSet;
    logic                  w_jumpNext;

    // Signed sum is kept wide enough that cnt+1 and cnt-NWB never wrap, so the
    // sign bit alone detects underflow. Register 0 is skipped and stays zero.
    always_comb begin
        w_cntNext = '0;
        w_ovfHit  = '0;
        w_unfHit  = '0;
        for (int r = 1; r < NR; r++) begin
            logic          inc;
            logic [DW-1:0] dec;
            logic [SW-1:0] sum;
            inc = dispatch_valid_i && (dispatch_rd_i == AW'(r));
            dec = '0;
            for (int k = 0; k < NWB; k++) begin
                if (wb_valid_i[k] && (wb_rd_i[k] == AW'(r))) begin
                    dec = dec + DW'(1);
                end
            end
            sum = {{(SW-CW){1'b0}}, r_cnt[r]} + SW'(inc) - SW'(dec);
            if (sum[SW-1]) begin
                w_unfHit[r]  = 1'b1;
                w_cntNext[r] = '0;
            end else if (sum > SUM_MAX) begin
                w_ovfHit[r]  = 1'b1;
                w_cntNext[r] = CNT_MAX;
            end else begin
                w_cntNext[r] = sum[CW-1:0];
            end
        end
    end

    always_comb begin
        w_jumpSet  = dispatch_valid_i && dispatch_jump_i;
        w_jumpNext = w_jumpSet || (r_jumpLock && !jump_done_i);
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_cnt       <= '0;
            r_jumpLock  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush_i) begin
            r_cnt       <= '0;
            r_jumpLock  <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_cnt       <= w_cntNext;
            r_jumpLock  <= w_jumpNext;
            r_overflow  <= r_overflow  | (|w_ovfHit);
            r_underflow <= r_underflow | (|w_unfHit);
        end
    end

    // Outputs decode only registered state so the lock/check loop has no
    // combinational path back from the arbiter.
    always_comb begin
        locks_o   = '0;
        rd_full_o = '0;
        for (int r = 0; r < NR; r++) begin
            locks_o[r]   = r_jumpLock || (r_cnt[r] != '0);
            rd_full_o[r] = (r_cnt[r] == CNT_MAX);
        end
    end

    assign jump_lock_o = r_jumpLock;
    assign overflow_o  = r_overflow;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Directed self-checking bench for reg_lock_tracker with hand-computed
// expectations for counters, jump lock, sticky flags, flush and async reset.

module tb_reg_lock_tracker;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF;

    logic                clk;
    logic                arst;
    logic                flush;
    logic                dispatchValid;
    logic                dispatchJump;
    logic [AW-1:0]       dispatchRd;
    logic                jumpDone;
    logic [1:0]          wbValid;
    logic [1:0][AW-1:0]  wbRd;
    logic [NR-1:0]       locks;
    logic [NR-1:0]       rdFull;
    logic                jumpLock;
    logic                overflow;
    logic                underflow;

    int testCount = 0;
    int failCount = 0;

    reg_lock_tracker #(.NR(NR), .CW(2), .NWB(2)) dut (
        .clk_i            (clk),
        .arst_i           (arst),
        .flush_i          (flush),
        .dispatch_valid_i (dispatchValid),
        .dispatch_jump_i  (dispatchJump),
        .dispatch_rd_i    (dispatchRd),
        .jump_done_i      (jumpDone),
        .wb_valid_i       (wbValid),
        .wb_rd_i          (wbRd),
        .locks_o          (locks),
        .rd_full_o        (rdFull),
        .jump_lock_o      (jumpLock),
        .overflow_o       (overflow),
        .underflow_o      (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [63:0] expLocks,
                            input logic [63:0] expFull, input logic expJump,
                            input logic expOvf, input logic expUnf);
        checkOutput({tag, ".locks"},     64'(locks),     expLocks);
        checkOutput({tag, ".rdFull"},    64'(rdFull),    expFull);
        checkOutput({tag, ".jumpLock"},  64'(jumpLock),  64'(expJump));
        checkOutput({tag, ".overflow"},  64'(overflow),  64'(expOvf));
        checkOutput({tag, ".underflow"}, 64'(underflow), 64'(expUnf));
    endtask

    task automatic setIdle();
        flush         = 1'b0;
        dispatchValid = 1'b0;
        dispatchJump  = 1'b0;
        dispatchRd    = '0;
        jumpDone      = 1'b0;
        wbValid       = '0;
        wbRd          = '0;
    endtask

    // Inputs are applied one edge later, then the bench sits at edge+1 for checks.
    task automatic applyStimulus(input logic dv, input logic jmp, input logic [AW-1:0] rd,
                                 input logic jd, input logic [1:0] wbv,
                                 input logic [AW-1:0] wb0, input logic [AW-1:0] wb1,
                                 input logic fl);
        dispatchValid = dv;
        dispatchJump  = jmp;
        dispatchRd    = rd;
        jumpDone      = jd;
        wbValid       = wbv;
        wbRd          = {wb1, wb0};
        flush         = fl;
        @(posedge clk);
        #1;
        setIdle();
    endtask

    task automatic doDispatch(input logic [AW-1:0] rd);
        applyStimulus(1'b1, 1'b0, rd, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic doWriteBack(input logic [AW-1:0] rd);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 2'b01, rd, '0, 1'b0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic doFlush();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 2'b00, '0, '0, 1'b1);
    endtask

    initial begin
        setIdle();
        arst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 1'b0, 1'b0, 1'b0);
        #3 arst = 1'b0;
        @(posedge clk);
        #1;
        checkAll("idle", 0, 0, 1'b0, 1'b0, 1'b0);

        doDispatch(5);
        checkAll("disp5", 64'h20, 0, 1'b0, 1'b0, 1'b0);
        doWriteBack(5);
        checkAll("wb5", 0, 0, 1'b0, 1'b0, 1'b0);

        doDispatch(3);
        doDispatch(3);
        checkAll("disp3x2", 64'h8, 0, 1'b0, 1'b0, 1'b0);
        doDispatch(3);
        checkAll("disp3x3", 64'h8, 64'h8, 1'b0, 1'b0, 1'b0);
        doDispatch(3);
        checkAll("disp3x4", 64'h8, 64'h8, 1'b0, 1'b1, 1'b0);
        doWriteBack(3);
        doWriteBack(3);
        checkAll("wb3x2", 64'h8, 0, 1'b0, 1'b1, 1'b0);
        doWriteBack(3);
        checkAll("wb3x3", 0, 0, 1'b0, 1'b1, 1'b0);
        doIdle();
        checkOutput("ovfSticky", 64'(overflow), 64'd1);
        doFlush();
        checkAll("flushOvf", 0, 0, 1'b0, 1'b0, 1'b0);

        doDispatch(7);
        checkOutput("disp7", 64'(locks), 64'h80);
        applyStimulus(1'b1, 1'b0, 7, 1'b0, 2'b01, 7, 0, 1'b0);
        checkAll("netOut7", 64'h80, 0, 1'b0, 1'b0, 1'b0);
        doDispatch(7);
        checkAll("disp7cnt2", 64'h80, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 2'b11, 7, 7, 1'b0);
        checkAll("dualWb7", 0, 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 1, 1'b0, 2'b00, 0, 0, 1'b0);
        checkAll("jump1", ALL_ONES, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 2'b00, 0, 0, 1'b0);
        checkAll("jumpDone", 64'h2, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1, 1'b1, 2'b00, 0, 0, 1'b0);
        checkAll("jumpSetWins", ALL_ONES, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 2'b00, 0, 0, 1'b0);
        checkAll("jumpDone2", 64'h2, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 1'b0, 2'b11, 1, 1, 1'b0);
        checkAll("wb1x2", 0, 0, 1'b0, 1'b0, 1'b0);

        doWriteBack(9);
        checkAll("unf9", 0, 0, 1'b0, 1'b0, 1'b1);
        doDispatch(9);
        checkAll("disp9", 64'h200, 0, 1'b0, 1'b0, 1'b1);
        doWriteBack(9);
        checkAll("wb9", 0, 0, 1'b0, 1'b0, 1'b1);
        doFlush();
        checkAll("flushUnf", 0, 0, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 0, 1'b0, 2'b11, 0, 0, 1'b0);
        checkAll("wbZero", 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) doDispatch(0);
        checkAll("dispZero", 0, 0, 1'b0, 1'b0, 1'b0);

        doDispatch(2);
        doDispatch(4);
        checkOutput("locks2and4", 64'(locks), 64'h14);
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0);
        doWriteBack(9);
        checkAll("preFlush", ALL_ONES, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 6, 1'b0, 2'b00, 0, 0, 1'b1);
        checkAll("flushWithDisp", 0, 0, 1'b0, 1'b0, 1'b0);
        doIdle();
        checkOutput("flushDropsDisp6", 64'(locks), 0);

        for (int i = 0; i < 4; i++) doDispatch(2);
        applyStimulus(1'b1, 1'b1, 0, 1'b0, 2'b00, 0, 0, 1'b0);
        checkAll("preReset", ALL_ONES, 64'h4, 1'b1, 1'b1, 1'b0);
        #2 arst = 1'b1;
        #1;
        checkAll("asyncReset", 0, 0, 1'b0, 1'b0, 1'b0);
        #2 arst = 1'b0;
        @(posedge clk);
        #1;
        doDispatch(5);
        checkAll("afterReset", 64'h20, 0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
